// File: rtl/expr_fsm_pkg.sv
// Shared constants for the expression FSM unit: state codes and mode selects.
package expr_fsm_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] ST_OPS  = 3'd1;
  localparam logic [STATE_W-1:0] ST_SUM1 = 3'd2;
  localparam logic [STATE_W-1:0] ST_SUM2 = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE = 3'd4;

  localparam logic [1:0] MODE_ALL    = 2'b00;
  localparam logic [1:0] MODE_ADDSUB = 2'b01;
  localparam logic [1:0] MODE_MUL    = 2'b10;
  localparam logic [1:0] MODE_SUBMUL = 2'b11;

endpackage

// File: rtl/expr_ops_stage.sv
// Registered sum/difference/product of two signed operands, full precision.
// Kept separate so the multiplier can later become a multi-cycle unit.
module expr_ops_stage #(
  parameter int unsigned IN_W  = 64,
  parameter int unsigned ACC_W = 2*IN_W+2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [IN_W-1:0]  a,
  input  logic signed [IN_W-1:0]  b,
  output logic signed [ACC_W-1:0] s,
  output logic signed [ACC_W-1:0] d,
  output logic signed [ACC_W-1:0] p
);

  logic signed [ACC_W-1:0] a_x;
  logic signed [ACC_W-1:0] b_x;

  // Sign-extend operands so no result can overflow the accumulator width.
  assign a_x = ACC_W'(a);
  assign b_x = ACC_W'(b);

  // Capture the three partial results while enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s <= '0;
      d <= '0;
      p <= '0;
    end else if (en) begin
      s <= a_x + b_x;
      d <= a_x - b_x;
      p <= a_x * b_x;
    end
  end

endmodule

// File: rtl/expr_fsm_unit.sv
// Handshaked, mode-selected expression unit: combines sum, difference and
// product of two signed operands over a five-state registered schedule.
module expr_fsm_unit
  import expr_fsm_pkg::*;
#(
  parameter int unsigned IN_W  = 64,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  x,
  input  logic [IN_W-1:0]  y,
  input  logic [1:0]       mode,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out,
  output logic             ovf,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int unsigned ACC_W = 2*IN_W+2;

  logic [STATE_W-1:0]      state;
  logic [STATE_W-1:0]      state_nx;
  logic                    accept_c;
  logic                    ops_en_c;
  logic                    sum1_en_c;
  logic                    sum2_en_c;
  logic                    drain_c;

  logic signed [IN_W-1:0]  a_r;
  logic signed [IN_W-1:0]  b_r;
  logic [1:0]              m_r;
  logic signed [ACC_W-1:0] s;
  logic signed [ACC_W-1:0] d;
  logic signed [ACC_W-1:0] p;
  logic signed [ACC_W-1:0] t_r;
  logic signed [ACC_W-1:0] t_c;
  logic signed [ACC_W-1:0] r_c;
  logic signed [ACC_W-1:0] hi_c;
  logic                    ovf_c;

  // Next-state and stage enables; abort only cancels the arithmetic states.
  always_comb begin
    state_nx  = state;
    accept_c  = 1'b0;
    ops_en_c  = 1'b0;
    sum1_en_c = 1'b0;
    sum2_en_c = 1'b0;
    drain_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          accept_c = 1'b1;
          state_nx = ST_OPS;
        end
      end
      ST_OPS: begin
        ops_en_c = 1'b1;
        state_nx = abort ? ST_IDLE : ST_SUM1;
      end
      ST_SUM1: begin
        sum1_en_c = !abort;
        state_nx  = abort ? ST_IDLE : ST_SUM2;
      end
      ST_SUM2: begin
        sum2_en_c = !abort;
        state_nx  = abort ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          drain_c  = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Full-precision s/d/p generation.
  expr_ops_stage #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_ops (
    .clk (clk),
    .rst (rst),
    .en  (ops_en_c),
    .a   (a_r),
    .b   (b_r),
    .s   (s),
    .d   (d),
    .p   (p)
  );

  // First-level sum (zero for the product-only mode) and mode-selected result.
  always_comb begin
    t_c = (m_r == MODE_MUL) ? '0 : s + d;
    case (m_r)
      MODE_ALL:    r_c = t_r + p;
      MODE_ADDSUB: r_c = t_r;
      MODE_MUL:    r_c = p;
      default:     r_c = t_r - p;
    endcase
  end

  // Result fits signed OUT_W only if every bit above the output sign bit
  // equals it, i.e. the arithmetic shift leaves all zeros or all ones.
  always_comb begin
    hi_c  = r_c >>> (OUT_W-1);
    ovf_c = (hi_c != '0) && (hi_c != '1);
  end

  // Operand latch, pipeline registers, result and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r       <= '0;
      b_r       <= '0;
      m_r       <= '0;
      t_r       <= '0;
      out       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      done_cnt  <= '0;
    end else begin
      if (accept_c) begin
        a_r <= x;
        b_r <= y;
        m_r <= mode;
      end
      if (sum1_en_c) t_r <= t_c;
      if (sum2_en_c) begin
        out <= r_c[OUT_W-1:0];
        ovf <= ovf_c;
      end
      if (drain_c) done_cnt <= done_cnt + CNT_W'(1);
      in_ready  <= (state_nx == ST_IDLE);
      out_valid <= (state_nx == ST_DONE);
    end
  end

endmodule

// File: tb/tb_expr_fsm_unit.sv
// Scoreboard bench for expr_fsm_unit: directed transactions push expected
// results, a negedge monitor pops and compares on every output transfer.
module tb_expr_fsm_unit;

  localparam int unsigned IN_W  = 64;
  localparam int unsigned OUT_W = 16;
  localparam int unsigned CNT_W = 16;

  typedef struct packed {
    logic [OUT_W-1:0] o;
    logic             v;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  x;
  logic [IN_W-1:0]  y;
  logic [1:0]       mode;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out;
  logic             ovf;
  logic [CNT_W-1:0] done_cnt;

  logic             w2_in_ready;
  logic             w2_out_valid;
  logic [OUT_W-1:0] w2_out;
  logic             w2_ovf;
  logic [1:0]       w2_done_cnt;

  exp_t q[$];
  int   n_cmp;
  int   n_fail;

  expr_fsm_unit #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .mode(mode), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .ovf(ovf), .done_cnt(done_cnt)
  );

  expr_fsm_unit #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w2_in_ready),
    .x(x), .y(y), .mode(mode), .abort(abort),
    .out_valid(w2_out_valid), .out_ready(out_ready),
    .out(w2_out), .ovf(w2_ovf), .done_cnt(w2_done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_out: got out=0x%0h ovf=%0b with nothing expected", out, ovf);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sb_out", 64'(out), 64'(e.o));
        check("sb_ovf", 64'(ovf), 64'(e.v));
      end
    end
  end

  // Present one operand set and return just after the accept edge.
  task automatic issue(input logic [IN_W-1:0] xv, input logic [IN_W-1:0] yv, input logic [1:0] mv);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
    x = xv; y = yv; mode = mv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("in_ready_drop", 64'(in_ready), 64'd0);
  endtask

  // Full transaction with out_ready high; optionally check latency.
  task automatic run_txn(input logic [IN_W-1:0] xv, input logic [IN_W-1:0] yv,
                         input logic [1:0] mv, input logic [OUT_W-1:0] eo,
                         input logic ev, input bit chk_lat, input logic [CNT_W-1:0] ecnt);
    int lat;
    exp_t e;
    e.o = eo; e.v = ev;
    q.push_back(e);
    issue(xv, yv, mv);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (chk_lat) check("latency_edges_after_accept", 64'(lat), 64'd3);
    else if (!out_valid) check("out_valid_timeout", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    check("out_valid_fall", 64'(out_valid), 64'd0);
    check("done_cnt", 64'(done_cnt), 64'(ecnt));
  endtask

  initial begin
    bit seen;
    int n;
    n_cmp = 0; n_fail = 0;
    rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; mode = 2'b00;
    abort = 1'b0; out_ready = 1'b1;
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out", 64'(out), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_done_cnt", 64'(done_cnt), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Basic modes on x=10, y=20: 2x=20, xy=200.
    run_txn(64'd10, 64'd20, 2'b00, 16'h00DC, 1'b0, 1'b1, 16'd1);
    run_txn(64'd10, 64'd20, 2'b01, 16'h0014, 1'b0, 1'b1, 16'd2);
    run_txn(64'd10, 64'd20, 2'b10, 16'h00C8, 1'b0, 1'b0, 16'd3);
    run_txn(64'd10, 64'd20, 2'b11, 16'hFF4C, 1'b0, 1'b0, 16'd4);
    // Overflow boundary and negative operand.
    run_txn(64'd300, 64'd300, 2'b10, 16'h5F90, 1'b1, 1'b0, 16'd5);
    run_txn(-64'sd128, 64'd1, 2'b01, 16'hFF00, 1'b0, 1'b0, 16'd6);
    // -32768 is the most negative representable value: no overflow.
    run_txn(-64'sd16384, 64'd0, 2'b01, 16'h8000, 1'b0, 1'b0, 16'd7);
    // 32768 is one past the most positive: overflow.
    run_txn(64'd16384, 64'd0, 2'b01, 16'h8000, 1'b1, 1'b0, 16'd8);

    // Backpressure: 2*5 + 5*3 = 25.
    out_ready = 1'b0;
    begin
      exp_t e;
      e.o = 16'h0019; e.v = 1'b0;
      q.push_back(e);
    end
    issue(64'd5, 64'd3, 2'b00);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_out_valid", 64'(out_valid), 64'd1);
    x = 64'd99; y = 64'd99; mode = 2'b10; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_out", 64'(out), 64'h19);
      check("bp_hold_ovf", 64'(ovf), 64'd0);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_valid_held", 64'(out_valid), 64'd1);
      check("bp_done_cnt", 64'(done_cnt), 64'd8);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_drained", 64'(out_valid), 64'd0);
    check("bp_done_cnt_once", 64'(done_cnt), 64'd9);
    repeat (8) @(posedge clk);
    #1;
    check("bp_no_extra_cnt", 64'(done_cnt), 64'd9);
    check("bp_no_extra_valid", 64'(out_valid), 64'd0);

    // Abort in SUM1: accept edge -> OPS, next edge -> SUM1.
    issue(64'd7, 64'd2, 2'b00);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_out", 64'(out), 64'h19);
    check("abort_ovf", 64'(ovf), 64'd0);
    check("abort_done_cnt", 64'(done_cnt), 64'd9);
    run_txn(64'd7, 64'd2, 2'b00, 16'h001C, 1'b0, 1'b0, 16'd10);

    // Async reset pulse while in SUM2, between clock edges.
    issue(64'd9, 64'd9, 2'b10);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out", 64'(out), 64'd0);
    check("arst_ovf", 64'(ovf), 64'd0);
    check("arst_done_cnt", 64'(done_cnt), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    #2 rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("arst_no_output", 64'(seen), 64'd0);
    check("arst_cnt_after", 64'(done_cnt), 64'd0);

    // Five transfers: wide counter reads 5, 2-bit counter wraps to 1.
    for (int i = 1; i <= 5; i++)
      run_txn(64'd3, 64'd4, 2'b01, 16'h0006, 1'b0, 1'b0, CNT_W'(i));
    check("wrap_cnt2", 64'(w2_done_cnt), 64'd1);

    repeat (3) @(posedge clk);
    check("sb_queue_empty", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Absolute time bound in case a handshake never completes.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
